// File: rtl/dram_access_ctrl.sv
// Load/store sequencer: one word-aligned req/ack bus transaction per access,
// core stall while in flight, formatted load data, misalign and timeout pulses.
module dram_access_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  store_sel,
  input  logic [2:0]  load_sel,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        timeout_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              misalign_q, misalign_d;
  logic              tmo_q, tmo_d;
  logic [2:0]        ld_sel_q, ld_sel_d;
  logic [1:0]        lane_q, lane_d;

  logic acc, is_half, is_byte, misaligned;

  function automatic logic [31:0] fmt_load(input logic [2:0] sel, input logic [1:0] lane,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (sel)
      3'b001:  fmt_load = {{16{h[15]}}, h};
      3'b010:  fmt_load = {{24{b[7]}}, b};
      3'b011:  fmt_load = {16'b0, h};
      3'b100:  fmt_load = {24'b0, b};
      default: fmt_load = w;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic wr, input logic [1:0] sel,
                                          input logic [1:0] lane);
    if (!wr)               store_be = 4'b1111;
    else if (sel == 2'b01) store_be = lane[1] ? 4'b1100 : 4'b0011;
    else if (sel == 2'b10) store_be = 4'b0001 << lane;
    else                   store_be = 4'b1111;
  endfunction

  function automatic logic [31:0] store_data(input logic wr, input logic [1:0] sel,
                                             input logic [31:0] w);
    if (!wr)               store_data = 32'b0;
    else if (sel == 2'b01) store_data = {2{w[15:0]}};
    else if (sel == 2'b10) store_data = {4{w[7:0]}};
    else                   store_data = w;
  endfunction

  // A write takes precedence when both mem_rd and mem_wr are asserted.
  assign acc = mem_rd | mem_wr;

  always_comb begin
    if (mem_wr) begin
      is_half = (store_sel == 2'b01);
      is_byte = (store_sel == 2'b10);
    end else begin
      is_half = (load_sel == 3'b001) || (load_sel == 3'b011);
      is_byte = (load_sel == 3'b010) || (load_sel == 3'b100);
    end
    misaligned = is_byte ? 1'b0 : (is_half ? addr[0] : (addr[1:0] != 2'b00));
  end

  assign stall = acc & ~misaligned & (state_q != DONE);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rdata_d    = rdata_q;
    ld_sel_d   = ld_sel_q;
    lane_d     = lane_q;
    misalign_d = 1'b0;
    tmo_d      = 1'b0;
    case (state_q)
      IDLE: begin
        req_d = 1'b0;
        if (acc) begin
          if (misaligned) begin
            misalign_d = 1'b1;
          end else begin
            we_d     = mem_wr;
            addr_d   = {addr[31:2], 2'b00};
            be_d     = store_be(mem_wr, store_sel, addr[1:0]);
            wdata_d  = store_data(mem_wr, store_sel, wdata);
            ld_sel_d = load_sel;
            lane_d   = addr[1:0];
            cnt_d    = '0;
            req_d    = 1'b1;
            state_d  = REQ;
          end
        end
      end
      REQ: begin
        // An ack arriving on the final allowed cycle still completes normally.
        if (bus_ack) begin
          if (!we_q) rdata_d = fmt_load(ld_sel_q, lane_q, bus_rdata);
          cnt_d   = '0;
          req_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          if (!we_q) rdata_d = 32'b0;
          tmo_d   = 1'b1;
          cnt_d   = '0;
          req_d   = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'b0;
      wdata_q    <= 32'b0;
      be_q       <= 4'b0;
      rdata_q    <= 32'b0;
      misalign_q <= 1'b0;
      tmo_q      <= 1'b0;
      ld_sel_q   <= 3'b0;
      lane_q     <= 2'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
      tmo_q      <= tmo_d;
      ld_sel_q   <= ld_sel_d;
      lane_q     <= lane_d;
    end
  end

  assign bus_req     = req_q;
  assign bus_we      = we_q;
  assign bus_addr    = addr_q;
  assign bus_wdata   = wdata_q;
  assign bus_be      = be_q;
  assign rdata       = rdata_q;
  assign misalign    = misalign_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_dram_access_ctrl.sv
// Directed bench for dram_access_ctrl: expected transactions are queued when
// an access is driven and compared when the controller reaches DONE.
module tb_dram_access_ctrl;

  localparam int TMO = 4;

  logic        clk, rst_n;
  logic        mem_rd, mem_wr;
  logic [31:0] addr, wdata;
  logic [1:0]  store_sel;
  logic [2:0]  load_sel;
  logic        stall, misalign, timeout_err;
  logic [31:0] rdata;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        tmo;
    int          nreq;
  } exp_t;

  exp_t sb_q[$];

  dram_access_ctrl #(.TIMEOUT(TMO), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .mem_rd(mem_rd), .mem_wr(mem_wr), .addr(addr),
    .wdata(wdata), .store_sel(store_sel), .load_sel(load_sel), .stall(stall),
    .rdata(rdata), .misalign(misalign), .timeout_err(timeout_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic we, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] be, input logic [31:0] rd,
                              input logic tmo, input int nreq);
    exp_t e;
    e.we = we; e.addr = a; e.wdata = wd; e.be = be;
    e.rdata = rd; e.tmo = tmo; e.nreq = nreq;
    return e;
  endfunction

  task automatic clear_inputs();
    mem_rd = 1'b0; mem_wr = 1'b0; addr = 32'b0; wdata = 32'b0;
    store_sel = 2'b00; load_sel = 3'b000;
  endtask

  // Called just after a rising edge with the controller in IDLE; returns
  // just after the edge that leaves DONE, so a following call is back-to-back.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] ss, input logic [2:0] ls,
                        input int ack_at, input logic [31:0] rword, input exp_t e);
    int   nreq;
    exp_t f;
    sb_q.push_back(e);
    mem_rd = rd; mem_wr = wr; addr = a; wdata = wd; store_sel = ss; load_sel = ls;
    @(negedge clk);
    chk({tag, ".stall_idle"}, 32'(stall), 32'd1);
    chk({tag, ".tmo_idle"}, 32'(timeout_err), 32'd0);
    chk({tag, ".req_idle"}, 32'(bus_req), 32'd0);
    @(posedge clk); #1;
    nreq = 0;
    for (int k = 1; k <= TMO + 2; k++) begin
      bus_ack   = (k == ack_at);
      bus_rdata = rword;
      @(negedge clk);
      if (bus_req) nreq++;
      if (k == 1) begin
        chk({tag, ".stall_req"}, 32'(stall), 32'd1);
        chk({tag, ".addr"}, bus_addr, sb_q[0].addr);
        chk({tag, ".be"}, 32'(bus_be), 32'(sb_q[0].be));
        chk({tag, ".we"}, 32'(bus_we), 32'(sb_q[0].we));
        if (sb_q[0].we) chk({tag, ".wdata"}, bus_wdata, sb_q[0].wdata);
      end
      @(posedge clk); #1;
      bus_ack = 1'b0;
      if (k == ack_at || k == TMO) break;
    end
    @(negedge clk);
    f = sb_q.pop_front();
    chk({tag, ".req_done"}, 32'(bus_req), 32'd0);
    chk({tag, ".stall_done"}, 32'(stall), 32'd0);
    chk({tag, ".tmo"}, 32'(timeout_err), 32'(f.tmo));
    chk({tag, ".rdata"}, rdata, f.rdata);
    chk({tag, ".nreq"}, 32'(nreq), 32'(f.nreq));
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic misaligned_access(input string tag, input logic rd, input logic wr,
                                   input logic [31:0] a, input logic [1:0] ss,
                                   input logic [2:0] ls);
    mem_rd = rd; mem_wr = wr; addr = a; wdata = 32'h0; store_sel = ss; load_sel = ls;
    @(negedge clk);
    chk({tag, ".stall"}, 32'(stall), 32'd0);
    chk({tag, ".mis_pre"}, 32'(misalign), 32'd0);
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    chk({tag, ".mis_pulse"}, 32'(misalign), 32'd1);
    chk({tag, ".req"}, 32'(bus_req), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, ".mis_end"}, 32'(misalign), 32'd0);
    chk({tag, ".req_after"}, 32'(bus_req), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; bus_ack = 1'b0; bus_rdata = 32'b0;
    clear_inputs();
    #12;
    chk("rst.req", 32'(bus_req), 32'd0);
    chk("rst.we", 32'(bus_we), 32'd0);
    chk("rst.addr", bus_addr, 32'd0);
    chk("rst.wdata", bus_wdata, 32'd0);
    chk("rst.be", 32'(bus_be), 32'd0);
    chk("rst.rdata", rdata, 32'd0);
    chk("rst.mis", 32'(misalign), 32'd0);
    chk("rst.tmo", 32'(timeout_err), 32'd0);
    chk("rst.stall", 32'(stall), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Stores: lane replication and byte enables; rdata stays 0.
    access("sw", 0, 1, 32'h100, 32'hDEADBEEF, 2'b00, 3'b000, 1, 32'h0,
           mk(1, 32'h100, 32'hDEADBEEF, 4'b1111, 32'h0, 0, 1));
    access("sb", 0, 1, 32'h103, 32'h000000A5, 2'b10, 3'b000, 1, 32'h0,
           mk(1, 32'h100, 32'hA5A5A5A5, 4'b1000, 32'h0, 0, 1));
    access("sh", 0, 1, 32'h102, 32'h1234BEEF, 2'b01, 3'b000, 2, 32'h0,
           mk(1, 32'h100, 32'hBEEFBEEF, 4'b1100, 32'h0, 0, 2));
    access("sh_lo", 0, 1, 32'h100, 32'h00007777, 2'b01, 3'b000, 1, 32'h0,
           mk(1, 32'h100, 32'h77777777, 4'b0011, 32'h0, 0, 1));

    // Loads with ack on the third REQ cycle: sign/zero extension per lane.
    access("lb", 1, 0, 32'h201, 32'h0, 2'b00, 3'b010, 3, 32'h123480FF,
           mk(0, 32'h200, 32'h0, 4'b1111, 32'hFFFFFF80, 0, 3));
    access("lbu", 1, 0, 32'h201, 32'h0, 2'b00, 3'b100, 3, 32'h123480FF,
           mk(0, 32'h200, 32'h0, 4'b1111, 32'h00000080, 0, 3));
    access("lh", 1, 0, 32'h202, 32'h0, 2'b00, 3'b001, 3, 32'h123480FF,
           mk(0, 32'h200, 32'h0, 4'b1111, 32'h00001234, 0, 3));
    access("lh_lo", 1, 0, 32'h200, 32'h0, 2'b00, 3'b001, 1, 32'h123480FF,
           mk(0, 32'h200, 32'h0, 4'b1111, 32'hFFFF80FF, 0, 1));
    access("lhu_lo", 1, 0, 32'h200, 32'h0, 2'b00, 3'b011, 1, 32'h123480FF,
           mk(0, 32'h200, 32'h0, 4'b1111, 32'h000080FF, 0, 1));
    access("lw", 1, 0, 32'h204, 32'h0, 2'b00, 3'b000, 1, 32'hCAFEF00D,
           mk(0, 32'h204, 32'h0, 4'b1111, 32'hCAFEF00D, 0, 1));

    // rd and wr together is a write; store_sel 11 behaves as sw; rdata kept.
    access("rdwr", 1, 1, 32'h208, 32'h11223344, 2'b11, 3'b010, 1, 32'h55555555,
           mk(1, 32'h208, 32'h11223344, 4'b1111, 32'hCAFEF00D, 0, 1));

    misaligned_access("mis_lw", 1, 0, 32'h102, 2'b00, 3'b000);
    misaligned_access("mis_lh", 1, 0, 32'h101, 2'b00, 3'b001);
    misaligned_access("mis_sw", 0, 1, 32'h101, 2'b00, 3'b000);

    // Timeout: no ack for TMO cycles clears rdata; ack on the last cycle wins.
    access("tmo", 1, 0, 32'h300, 32'h0, 2'b00, 3'b000, 0, 32'hFFFFFFFF,
           mk(0, 32'h300, 32'h0, 4'b1111, 32'h0, 1, TMO));
    access("ack_last", 1, 0, 32'h304, 32'h0, 2'b00, 3'b000, TMO, 32'h55AA55AA,
           mk(0, 32'h304, 32'h0, 4'b1111, 32'h55AA55AA, 0, TMO));

    // Asynchronous reset in the middle of REQ.
    mem_rd = 1'b1; addr = 32'h400; load_sel = 3'b000;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid.req_before", 32'(bus_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid.req", 32'(bus_req), 32'd0);
    chk("rstmid.rdata", rdata, 32'd0);
    chk("rstmid.addr", bus_addr, 32'd0);
    clear_inputs();
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rstmid.req_idle", 32'(bus_req), 32'd0);
    access("post_rst_lw", 1, 0, 32'h400, 32'h0, 2'b00, 3'b000, 2, 32'h0BADC0DE,
           mk(0, 32'h400, 32'h0, 4'b1111, 32'h0BADC0DE, 0, 2));

    @(negedge clk);
    chk("end.req", 32'(bus_req), 32'd0);
    chk("end.stall", 32'(stall), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dram_access_ctrl.md
Name: dram_access_ctrl

Overview:
Multi-cycle sequencer between the core's load/store datapath and a data memory with a req/ack handshake and variable latency. It takes the decoder's memory controls (dram_we, store_sel, wd_dram_sel) plus the address and store data. It drives one word-aligned bus transaction with byte enables, holds the core stalled until the transaction completes, then returns sign- or zero-extended load data. It also flags misaligned accesses and bus timeouts so the core cannot hang.

Parameters:
TIMEOUT, 255, number of REQ cycles without bus_ack before the access is aborted (1..65535)
CNT_W, 16, width of the timeout counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
mem_rd  in  1  load instruction present (opcode == load)
mem_wr  in  1  store instruction present (dram_we)
addr  in  32  byte address from ALU
wdata  in  32  store data (rs2)
store_sel  in  2  00 sw, 01 sh, 10 sb, 11 treated as sw
load_sel  in  3  000 lw, 001 lh, 010 lb, 011 lhu, 100 lbu, others treated as lw
stall  out  1  hold PC / suppress writeback
rdata  out  32  formatted load result
misalign  out  1  one-cycle pulse: misaligned access rejected
timeout_err  out  1  one-cycle pulse: bus access aborted
bus_req  out  1  transaction request
bus_we  out  1  1 = write
bus_addr  out  32  {addr[31:2],2'b00}
bus_wdata  out  32  lane-replicated store data
bus_be  out  4  byte enables
bus_ack  in  1  transaction complete; bus_rdata valid this cycle
bus_rdata  in  32  read word

Behaviour:
- Access request: acc = mem_rd | mem_wr. If both are high, the access is a write (mem_rd is ignored).
- Misaligned condition:
  - word access with addr[1:0] != 0
  - half access with addr[0] != 0
  - byte accesses are never misaligned
- FSM states IDLE, REQ, DONE. All bus outputs, rdata, misalign and timeout_err are registered.
- Reset (async, any state): state=IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0, rdata=0, misalign=0, timeout_err=0, counter=0. A reset mid-REQ drops bus_req immediately.
- IDLE:
  - acc and aligned: latch bus_we, bus_addr, bus_be, bus_wdata, load_sel and addr[1:0]; go to REQ.
  - acc and misaligned: misalign=1 next cycle; no bus activity; stay IDLE.
  - no acc: stay IDLE.
- REQ:
  - bus_req=1; bus_addr/bus_we/bus_be/bus_wdata held stable until ack.
  - Counter increments each cycle.
  - bus_ack: capture formatted bus_rdata into rdata (loads only; stores leave rdata unchanged); clear counter; go to DONE.
  - Counter reaches TIMEOUT-1 without ack: timeout_err=1 next cycle; rdata=0 for loads; go to DONE.
  - Ack on the timeout cycle: ack wins, no error.
- DONE: bus_req=0. Next state is always IDLE.
- bus_ack outside REQ is ignored.
- stall (combinational) = acc & ~misaligned & (state != DONE). The core advances at the end of the DONE cycle. Minimum stall is 2 cycles (IDLE, REQ with immediate ack), with writeback in DONE.
- Misaligned access: stall=0 in that cycle; the trap is handled externally.
- Byte enables and write data:
  - sw: be=1111, data=wdata.
  - sh: be=addr[1] ? 1100 : 0011; data={2{wdata[15:0]}}.
  - sb: be=0001<<addr[1:0]; data={4{wdata[7:0]}}.
  - Reads: be=1111.
- Load formatting: lane = addr[1:0] latched at request.
  - lb/lbu: byte bus_rdata[8*lane+:8], sign-/zero-extended.
  - lh/lhu: bus_rdata[16*addr[1]+:16], sign-/zero-extended.
  - lw: full word.
- Back-to-back accesses: a new access in the cycle after DONE starts normally from IDLE; no bubble beyond the IDLE cycle.

Test Plan:
- sw addr=0x100 wdata=0xDEADBEEF, ack on 1st REQ cycle → bus_be=1111, bus_addr=0x100, bus_we=1, stall high 2 cycles, low in DONE.
- sb addr=0x103 wdata=0x000000A5 → bus_be=1000, bus_wdata=0xA5A5A5A5; sh addr=0x102 → bus_be=1100.
- lb addr=0x201, bus_rdata=0x1234_80FF, ack after 3 cycles → rdata=0xFFFFFF80; lbu same → 0x00000080; lh addr=0x202 → 0x00001234.
- lw addr=0x102 → misalign pulse 1 cycle, bus_req never asserts, stall=0; lh addr=0x101 → same.
- TIMEOUT=4, load with no ack → bus_req high 4 cycles, timeout_err pulse, rdata=0, stall released in DONE. Ack on the 4th cycle → no error, data captured.
- rst_n low during REQ → bus_req=0 immediately, state IDLE. After release, a new lw completes normally.
